// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit a+b+cin, one CHUNK-wide ripple per stage.
// Optional macro PIPE_RCA_OVF_EN adds the registered signed-overflow port ovf.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_RCA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);
    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("WIDTH must be a positive multiple of STAGES");
    end

    // Per-stage inputs: remaining operands shifted to bit 0,
    // partial sum so far, incoming carry and incoming valid.
    wire  [WIDTH-1:0] w_opa [STAGES];
    wire  [WIDTH-1:0] w_opb [STAGES];
    wire  [WIDTH-1:0] w_ps  [STAGES];
    wire              w_ci  [STAGES];
    wire              w_vi  [STAGES];
    // Per-stage register outputs
    wire  [WIDTH-1:0] w_s   [STAGES];
    wire              w_c   [STAGES];
    wire              w_v   [STAGES];
`ifdef PIPE_RCA_OVF_EN
    wire  [CHUNK-1:0] w_cs  [STAGES];
`endif
    logic [STAGES-1:0] w_rdy;

    assign w_opa[0] = a;
    assign w_opb[0] = b;
    assign w_ps[0]  = '0;
    assign w_ci[0]  = cin;
    assign w_vi[0]  = in_valid;

    // Ready chain: a stage loads when empty or when its successor moves on
    always_comb begin
        logic v_r;
        w_rdy = '0;
        v_r   = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            v_r      = !w_v[k] | v_r;
            w_rdy[k] = v_r;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [CHUNK-1:0] w_sum;
        logic             w_co;
        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_s;

        // Chunk k: plain ripple of CHUNK full adders
        always_comb begin
            logic v_c;
            v_c   = w_ci[k];
            w_sum = '0;
            for (int i = 0; i < CHUNK; i++) begin
                w_sum[i] = w_opa[k][i] ^ w_opb[k][i] ^ v_c;
                v_c = (w_opa[k][i] & w_opb[k][i]) |
                      (v_c & (w_opa[k][i] ^ w_opb[k][i]));
            end
            w_co = v_c;
        end

        // Stage register: valid, finished sum chunks, chunk carry-out
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_rdy[k]) begin
                r_v <= w_vi[k];
                r_c <= w_co;
                r_s <= w_ps[k] | (WIDTH'(w_sum) << (k * CHUNK));
            end
        end

        assign w_s[k] = r_s;
        assign w_c[k] = r_c;
        assign w_v[k] = r_v;
`ifdef PIPE_RCA_OVF_EN
        assign w_cs[k] = w_sum;
`endif

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] r_na;
            logic [WIDTH-1:0] r_nb;

            // Carry the not-yet-added operand chunks forward, shifted down
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_na <= '0;
                    r_nb <= '0;
                end else if (w_rdy[k]) begin
                    r_na <= w_opa[k] >> CHUNK;
                    r_nb <= w_opb[k] >> CHUNK;
                end
            end

            assign w_opa[k+1] = r_na;
            assign w_opb[k+1] = r_nb;
            assign w_ps[k+1]  = r_s;
            assign w_ci[k+1]  = r_c;
            assign w_vi[k+1]  = r_v;
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_v[STAGES-1];
    assign sum       = w_s[STAGES-1];
    assign cout      = w_c[STAGES-1];

`ifdef PIPE_RCA_OVF_EN
    localparam int L = STAGES - 1;
    logic r_ovf;

    // Operand MSBs and the sum MSB all sit in the last chunk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_rdy[L]) begin
            r_ovf <= (w_opa[L][CHUNK-1] == w_opb[L][CHUNK-1]) &
                     (w_cs[L][CHUNK-1] != w_opa[L][CHUNK-1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
